// File: rtl/tl_sink_allocator.sv
// TileLink sink allocator.
// Upstream managers see a HostSinkWidth-bit sink namespace. Each Grant/GrantData
// from the downstream manager takes the lowest free local entry. That entry
// remembers the device sink until the matching GrantAck (E) returns it.
// A, B and C pass straight through.
//
// Payload layouts (MSB first, flat vectors):
//   A: opcode[3] param[3] size source address mask corrupt data
//   B: opcode[3] param[2] size source address mask corrupt data
//   C: opcode[3] param[3] size source address corrupt data
//   D: opcode[3] param[2] size source sink denied corrupt data
//   E: sink
module tl_sink_allocator #(
  parameter int DataWidth       = 64,
  parameter int AddrWidth       = 56,
  parameter int SourceWidth     = 1,
  parameter int HostSinkWidth   = 2,
  parameter int DeviceSinkWidth = 1,
  parameter int MaxSize         = 6,
  localparam int SizeWidth      = $clog2(MaxSize + 1),
  localparam int MaskWidth      = DataWidth / 8,
  localparam int AWidth         = 3 + 3 + SizeWidth + SourceWidth + AddrWidth + MaskWidth + 1 + DataWidth,
  localparam int BWidth         = 3 + 2 + SizeWidth + SourceWidth + AddrWidth + MaskWidth + 1 + DataWidth,
  localparam int CWidth         = 3 + 3 + SizeWidth + SourceWidth + AddrWidth + 1 + DataWidth,
  localparam int HostDWidth     = 3 + 2 + SizeWidth + SourceWidth + HostSinkWidth + 2 + DataWidth,
  localparam int DeviceDWidth   = 3 + 2 + SizeWidth + SourceWidth + DeviceSinkWidth + 2 + DataWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // upstream side
  input  logic                       host_a_valid,
  output logic                       host_a_ready,
  input  logic [AWidth-1:0]          host_a,
  output logic                       host_b_valid,
  input  logic                       host_b_ready,
  output logic [BWidth-1:0]          host_b,
  input  logic                       host_c_valid,
  output logic                       host_c_ready,
  input  logic [CWidth-1:0]          host_c,
  output logic                       host_d_valid,
  input  logic                       host_d_ready,
  output logic [HostDWidth-1:0]      host_d,
  input  logic                       host_e_valid,
  output logic                       host_e_ready,
  input  logic [HostSinkWidth-1:0]   host_e,
  // downstream side
  output logic                       device_a_valid,
  input  logic                       device_a_ready,
  output logic [AWidth-1:0]          device_a,
  input  logic                       device_b_valid,
  output logic                       device_b_ready,
  input  logic [BWidth-1:0]          device_b,
  output logic                       device_c_valid,
  input  logic                       device_c_ready,
  output logic [CWidth-1:0]          device_c,
  input  logic                       device_d_valid,
  output logic                       device_d_ready,
  input  logic [DeviceDWidth-1:0]    device_d,
  output logic                       device_e_valid,
  input  logic                       device_e_ready,
  output logic [DeviceSinkWidth-1:0] device_e
);

  localparam int NumEntries   = 2 ** HostSinkWidth;
  localparam int LgBeatBytes  = $clog2(DataWidth / 8);
  localparam int BeatCntWidth = (MaxSize > LgBeatBytes) ? (MaxSize - LgBeatBytes) : 1;

  localparam logic [2:0] OpAccessAckData = 3'd1;
  localparam logic [2:0] OpGrant         = 3'd4;
  localparam logic [2:0] OpGrantData     = 3'd5;

  typedef struct packed {
    logic [2:0]                 opcode;
    logic [1:0]                 param;
    logic [SizeWidth-1:0]       size;
    logic [SourceWidth-1:0]     source;
    logic [DeviceSinkWidth-1:0] sink;
    logic                       denied;
    logic                       corrupt;
    logic [DataWidth-1:0]       data;
  } device_d_t;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [1:0]               param;
    logic [SizeWidth-1:0]     size;
    logic [SourceWidth-1:0]   source;
    logic [HostSinkWidth-1:0] sink;
    logic                     denied;
    logic                     corrupt;
    logic [DataWidth-1:0]     data;
  } host_d_t;

  // Beats after the first in a D message; only data-carrying opcodes span beats.
  function automatic logic [BeatCntWidth-1:0] beat_len(input logic [2:0]           opcode,
                                                       input logic [SizeWidth-1:0] size);
    logic [BeatCntWidth-1:0] len;
    len = '0;
    if ((opcode == OpAccessAckData || opcode == OpGrantData) && int'(size) > LgBeatBytes) begin
      len = BeatCntWidth'((1 << (int'(size) - LgBeatBytes)) - 1);
    end
    return len;
  endfunction

  device_d_t                  dev_d;
  host_d_t                    host_d_s;

  logic [NumEntries-1:0]      entry_vld_q;
  logic [NumEntries-1:0]      entry_vld_d;
  logic [DeviceSinkWidth-1:0] entry_sink_q [NumEntries];
  logic [BeatCntWidth-1:0]    beat_cnt_q;
  logic [HostSinkWidth-1:0]   cur_idx_q;

  logic                       free_found;
  logic [HostSinkWidth-1:0]   free_idx;
  logic                       d_first;
  logic                       is_grant;
  logic                       stall;
  logic                       d_fire;
  logic                       alloc_fire;
  logic                       e_fire;

  assign device_a_valid = host_a_valid;
  assign host_a_ready   = device_a_ready;
  assign device_a       = host_a;

  assign host_b_valid   = device_b_valid;
  assign device_b_ready = host_b_ready;
  assign host_b         = device_b;

  assign device_c_valid = host_c_valid;
  assign host_c_ready   = device_c_ready;
  assign device_c       = host_c;

  assign dev_d = device_d;

  // Lowest-numbered entry free in the registered state; freeing this cycle does not count.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (!entry_vld_q[i]) begin
        free_found = 1'b1;
        free_idx   = HostSinkWidth'(i);
      end
    end
  end

  assign d_first  = (beat_cnt_q == '0);
  assign is_grant = (dev_d.opcode == OpGrant) || (dev_d.opcode == OpGrantData);
  // Only the first beat of a Grant needs an entry; later GrantData beats reuse cur_idx.
  assign stall    = device_d_valid && d_first && is_grant && !free_found;

  assign host_d_valid   = device_d_valid && !stall;
  assign device_d_ready = host_d_ready && !stall;
  assign d_fire         = device_d_valid && device_d_ready;
  assign alloc_fire     = d_fire && d_first && is_grant;

  // D payload forwarded unchanged apart from the sink rename.
  always_comb begin
    host_d_s         = '0;
    host_d_s.opcode  = dev_d.opcode;
    host_d_s.param   = dev_d.param;
    host_d_s.size    = dev_d.size;
    host_d_s.source  = dev_d.source;
    host_d_s.denied  = dev_d.denied;
    host_d_s.corrupt = dev_d.corrupt;
    host_d_s.data    = dev_d.data;
    if (is_grant) begin
      host_d_s.sink = d_first ? free_idx : cur_idx_q;
    end
  end

  assign host_d = host_d_s;

  assign device_e_valid = host_e_valid;
  assign host_e_ready   = device_e_ready;
  assign device_e       = entry_sink_q[host_e];
  assign e_fire         = host_e_valid && device_e_ready;

  // Entry occupancy update; the allocation is applied last so it wins an index clash.
  always_comb begin
    entry_vld_d = entry_vld_q;
    if (e_fire) begin
      entry_vld_d[host_e] = 1'b0;
    end
    if (alloc_fire) begin
      entry_vld_d[free_idx] = 1'b1;
    end
  end

  // Control state: occupancy, burst counter and the index owned by the current burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_vld_q <= '0;
      beat_cnt_q  <= '0;
      cur_idx_q   <= '0;
    end else begin
      entry_vld_q <= entry_vld_d;
      if (d_fire) begin
        beat_cnt_q <= d_first ? beat_len(dev_d.opcode, dev_d.size)
                              : beat_cnt_q - BeatCntWidth'(1);
      end
      if (alloc_fire) begin
        cur_idx_q <= free_idx;
      end
    end
  end

  // Device sink captured on allocation; meaningful only while the entry is valid.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      entry_sink_q[free_idx] <= dev_d.sink;
    end
  end

  // A GrantAck for an entry that was never granted means upstream lost track of its sinks.
  always @(posedge clk_i) begin
    if (!rst_i && e_fire) begin
      assert (entry_vld_q[host_e])
        else $error("tl_sink_allocator: E beat for unallocated sink %0d", host_e);
    end
  end

endmodule

// File: tb/tb_tl_sink_allocator.sv
// Testbench for tl_sink_allocator: D beats are queued with their expected host
// view when driven and compared when the host-side handshake occurs.
module tb_tl_sink_allocator;

  localparam int AW  = 139;
  localparam int BW  = 138;
  localparam int CW  = 131;

  localparam logic [2:0] OP_ACK_DATA   = 3'd1;
  localparam logic [2:0] OP_GRANT      = 3'd4;
  localparam logic [2:0] OP_GRANT_DATA = 3'd5;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [0:0]  source;
    logic [1:0]  sink;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } hd_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [0:0]  source;
    logic [0:0]  sink;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } dd_t;

  logic          clk_i, rst_i;
  logic          host_a_valid, host_a_ready;
  logic [AW-1:0] host_a;
  logic          host_b_valid, host_b_ready;
  logic [BW-1:0] host_b;
  logic          host_c_valid, host_c_ready;
  logic [CW-1:0] host_c;
  logic          host_d_valid, host_d_ready;
  hd_t           host_d;
  logic          host_e_valid, host_e_ready;
  logic [1:0]    host_e;
  logic          device_a_valid, device_a_ready;
  logic [AW-1:0] device_a;
  logic          device_b_valid, device_b_ready;
  logic [BW-1:0] device_b;
  logic          device_c_valid, device_c_ready;
  logic [CW-1:0] device_c;
  logic          device_d_valid, device_d_ready;
  dd_t           device_d;
  logic          device_e_valid, device_e_ready;
  logic [0:0]    device_e;

  int  checks = 0;
  int  errors = 0;
  hd_t exp_q[$];

  tl_sink_allocator dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .host_a_valid   (host_a_valid),
    .host_a_ready   (host_a_ready),
    .host_a         (host_a),
    .host_b_valid   (host_b_valid),
    .host_b_ready   (host_b_ready),
    .host_b         (host_b),
    .host_c_valid   (host_c_valid),
    .host_c_ready   (host_c_ready),
    .host_c         (host_c),
    .host_d_valid   (host_d_valid),
    .host_d_ready   (host_d_ready),
    .host_d         (host_d),
    .host_e_valid   (host_e_valid),
    .host_e_ready   (host_e_ready),
    .host_e         (host_e),
    .device_a_valid (device_a_valid),
    .device_a_ready (device_a_ready),
    .device_a       (device_a),
    .device_b_valid (device_b_valid),
    .device_b_ready (device_b_ready),
    .device_b       (device_b),
    .device_c_valid (device_c_valid),
    .device_c_ready (device_c_ready),
    .device_c       (device_c),
    .device_d_valid (device_d_valid),
    .device_d_ready (device_d_ready),
    .device_d       (device_d),
    .device_e_valid (device_e_valid),
    .device_e_ready (device_e_ready),
    .device_e       (device_e)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic dd_t mk_dd(input logic [2:0] op, input logic [2:0] size,
                                input logic sink, input logic [63:0] data);
    dd_t b;
    b.opcode  = op;
    b.param   = 2'd0;
    b.size    = size;
    b.source  = 1'b1;
    b.sink    = sink;
    b.denied  = 1'b0;
    b.corrupt = 1'b0;
    b.data    = data;
    return b;
  endfunction

  function automatic hd_t exp_of(input dd_t b, input logic [1:0] sink);
    hd_t h;
    h.opcode  = b.opcode;
    h.param   = b.param;
    h.size    = b.size;
    h.source  = b.source;
    h.sink    = sink;
    h.denied  = b.denied;
    h.corrupt = b.corrupt;
    h.data    = b.data;
    return h;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Presents one D beat (host ready) and compares the host beat at its handshake.
  task automatic d_beat(input dd_t beat, input logic [1:0] sink, input string name);
    hd_t expd;
    bit  done;
    exp_q.push_back(exp_of(beat, sink));
    device_d       = beat;
    device_d_valid = 1'b1;
    done           = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #4;
      if (host_d_valid === 1'b1 && device_d_ready === 1'b1) begin
        expd = exp_q.pop_front();
        checks++;
        if (host_d !== expd) begin
          errors++;
          $display("FAIL %s: host_d got %h expected %h", name, host_d, expd);
        end
        done = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    device_d_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: no D handshake within 20 cycles (expected sink %0d)", name, sink);
      void'(exp_q.pop_front());
    end
  endtask

  // Returns one sink on E and checks the translated device sink.
  task automatic e_beat(input logic [1:0] idx, input logic dev_sink, input string name);
    host_e         = idx;
    host_e_valid   = 1'b1;
    device_e_ready = 1'b1;
    #4;
    checks++;
    if (device_e_valid !== 1'b1 || host_e_ready !== 1'b1 || device_e !== dev_sink) begin
      errors++;
      $display("FAIL %s: device_e_valid=%b host_e_ready=%b device_e=%0d, expected 1/1/%0d",
               name, device_e_valid, host_e_ready, device_e, dev_sink);
    end
    @(posedge clk_i); #1;
    host_e_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_i          = 1'b1;
    host_d_ready   = 1'b0;
    device_e_ready = 1'b0;
    @(posedge clk_i); #1;
    host_a_valid   = 1'b1;
    host_c_valid   = 1'b1;
    device_b_valid = 1'b1;
    device_d       = mk_dd(OP_GRANT_DATA, 3'd6, 1'b1, 64'h1111_2222_3333_4444);
    device_d_valid = 1'b1;
    #4;
    checks++;
    if (host_d_valid !== 1'b1 || device_d_ready !== 1'b0 || host_d.sink !== 2'd0) begin
      errors++;
      $display("FAIL reset_d: valid=%b ready=%b sink=%0d, expected 1/0/0",
               host_d_valid, device_d_ready, host_d.sink);
    end
    checks++;
    if (device_a_valid !== 1'b1 || device_c_valid !== 1'b1 || host_b_valid !== 1'b1 ||
        device_e_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: a=%b c=%b b=%b e=%b, expected 1/1/1/0",
               device_a_valid, device_c_valid, host_b_valid, device_e_valid);
    end
    @(posedge clk_i); #1;
    host_a_valid   = 1'b0;
    host_c_valid   = 1'b0;
    device_b_valid = 1'b0;
    device_d_valid = 1'b0;
    host_e_valid   = 1'b1;
    #4;
    checks++;
    if (host_d_valid !== 1'b0 || device_e_valid !== 1'b1 || device_a_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_follow: host_d_valid=%b device_e_valid=%b device_a_valid=%b, expected 0/1/0",
               host_d_valid, device_e_valid, device_a_valid);
    end
    @(posedge clk_i); #1;
    host_e_valid   = 1'b0;
    rst_i          = 1'b0;
    host_d_ready   = 1'b1;
    device_e_ready = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_grant_basic();
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b1, rnd64()), 2'd0, "grant_first");
    e_beat(2'd0, 1'b1, "grant_first_e");
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b0, rnd64()), 2'd0, "grant_reuse0");
    e_beat(2'd0, 1'b0, "grant_reuse0_e");
  endtask

  task automatic test_grantdata_burst();
    for (int b = 0; b < 8; b++) begin
      d_beat(mk_dd(OP_GRANT_DATA, 3'd6, 1'b1, 64'hA5A5_0000_0000_0000 + 64'(b)), 2'd0, "gd_burst_beat");
    end
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b0, rnd64()), 2'd1, "grant_after_burst");
    e_beat(2'd0, 1'b1, "gd_burst_e0");
    e_beat(2'd1, 1'b0, "gd_burst_e1");
  endtask

  // Grant waits on a full table, then an E frees idx while the Grant is still pending.
  task automatic stall_then_free(input logic [1:0] idx, input logic freed_dev_sink,
                                 input logic new_dev_sink, input string name);
    dd_t g;
    hd_t expd;
    g = mk_dd(OP_GRANT, 3'd6, new_dev_sink, rnd64());
    exp_q.push_back(exp_of(g, idx));
    device_d       = g;
    device_d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if (host_d_valid !== 1'b0 || device_d_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_stall: host_d_valid=%b device_d_ready=%b, expected 0/0",
                 name, host_d_valid, device_d_ready);
      end
      @(posedge clk_i); #1;
    end
    host_e       = idx;
    host_e_valid = 1'b1;
    #4;
    checks++;
    if (host_d_valid !== 1'b0 || device_d_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall_on_free: host_d_valid=%b device_d_ready=%b, expected 0/0",
               name, host_d_valid, device_d_ready);
    end
    checks++;
    if (device_e_valid !== 1'b1 || device_e !== freed_dev_sink) begin
      errors++;
      $display("FAIL %s_e: device_e_valid=%b device_e=%0d, expected 1/%0d",
               name, device_e_valid, device_e, freed_dev_sink);
    end
    @(posedge clk_i); #1;
    host_e_valid = 1'b0;
    #4;
    checks++;
    if (host_d_valid !== 1'b1 || device_d_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: host_d_valid=%b device_d_ready=%b, expected 1/1",
               name, host_d_valid, device_d_ready);
    end
    expd = exp_q.pop_front();
    checks++;
    if (host_d !== expd) begin
      errors++;
      $display("FAIL %s_beat: host_d got %h expected %h", name, host_d, expd);
    end
    @(posedge clk_i); #1;
    device_d_valid = 1'b0;
  endtask

  task automatic test_full_stall();
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b1, rnd64()), 2'd0, "fill_0");
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b0, rnd64()), 2'd1, "fill_1");
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b1, rnd64()), 2'd2, "fill_2");
    d_beat(mk_dd(OP_GRANT_DATA, 3'd4, 1'b0, rnd64()), 2'd3, "fill_3_gd_first");
    d_beat(mk_dd(OP_GRANT_DATA, 3'd4, 1'b0, rnd64()), 2'd3, "fill_3_gd_second_while_full");
    stall_then_free(2'd2, 1'b1, 1'b0, "fifth_grant");
    stall_then_free(2'd1, 1'b0, 1'b1, "free_same_cycle");
    e_beat(2'd0, 1'b1, "drain_e0");
    e_beat(2'd1, 1'b1, "drain_e1");
    e_beat(2'd2, 1'b0, "drain_e2");
    e_beat(2'd3, 1'b0, "drain_e3");
  endtask

  task automatic test_ackdata_passthrough();
    hd_t expd;
    dd_t b;
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b1, rnd64()), 2'd0, "ack_pre_0");
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b0, rnd64()), 2'd1, "ack_pre_1");
    host_d_ready   = 1'b0;
    device_d       = mk_dd(OP_ACK_DATA, 3'd6, 1'b1, rnd64());
    device_d_valid = 1'b1;
    #4;
    checks++;
    if (host_d_valid !== 1'b1 || device_d_ready !== 1'b0) begin
      errors++;
      $display("FAIL ackdata_backpressure: host_d_valid=%b device_d_ready=%b, expected 1/0",
               host_d_valid, device_d_ready);
    end
    @(posedge clk_i); #1;
    host_d_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < AW; i++) host_a[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < BW; i++) device_b[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < CW; i++) host_c[i] = 1'($urandom_range(0, 1));
      host_a_valid   = 1'($urandom_range(0, 1));
      device_a_ready = 1'($urandom_range(0, 1));
      device_b_valid = 1'($urandom_range(0, 1));
      host_b_ready   = 1'($urandom_range(0, 1));
      host_c_valid   = 1'($urandom_range(0, 1));
      device_c_ready = 1'($urandom_range(0, 1));
      b = mk_dd(OP_ACK_DATA, 3'd6, 1'b1, rnd64());
      exp_q.push_back(exp_of(b, 2'd0));
      device_d = b;
      #4;
      checks++;
      if (device_a_valid !== host_a_valid || host_a_ready !== device_a_ready || device_a !== host_a) begin
        errors++;
        $display("FAIL a_passthrough: device_a %h v%b / host_a_ready %b, required %h v%b / %b",
                 device_a, device_a_valid, host_a_ready, host_a, host_a_valid, device_a_ready);
      end
      checks++;
      if (host_b_valid !== device_b_valid || device_b_ready !== host_b_ready || host_b !== device_b) begin
        errors++;
        $display("FAIL b_passthrough: host_b %h v%b / device_b_ready %b, required %h v%b / %b",
                 host_b, host_b_valid, device_b_ready, device_b, device_b_valid, host_b_ready);
      end
      checks++;
      if (device_c_valid !== host_c_valid || host_c_ready !== device_c_ready || device_c !== host_c) begin
        errors++;
        $display("FAIL c_passthrough: device_c %h v%b / host_c_ready %b, required %h v%b / %b",
                 device_c, device_c_valid, host_c_ready, host_c, host_c_valid, device_c_ready);
      end
      expd = exp_q.pop_front();
      checks++;
      if (host_d_valid !== 1'b1 || device_d_ready !== 1'b1 || host_d !== expd) begin
        errors++;
        $display("FAIL ackdata_beat: v%b r%b host_d %h, expected v1 r1 %h",
                 host_d_valid, device_d_ready, host_d, expd);
      end
      @(posedge clk_i); #1;
    end
    device_d_valid = 1'b0;
    host_a_valid   = 1'b0;
    device_b_valid = 1'b0;
    host_c_valid   = 1'b0;
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b1, rnd64()), 2'd2, "grant_after_ackdata");
    e_beat(2'd0, 1'b1, "ack_e0");
    e_beat(2'd1, 1'b0, "ack_e1");
    e_beat(2'd2, 1'b1, "ack_e2");
  endtask

  task automatic test_free_and_alloc();
    dd_t g;
    hd_t expd;
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b1, rnd64()), 2'd0, "fa_pre_0");
    g = mk_dd(OP_GRANT, 3'd6, 1'b0, rnd64());
    exp_q.push_back(exp_of(g, 2'd1));
    device_d       = g;
    device_d_valid = 1'b1;
    host_e         = 2'd0;
    host_e_valid   = 1'b1;
    #4;
    expd = exp_q.pop_front();
    checks++;
    if (host_d_valid !== 1'b1 || host_d !== expd) begin
      errors++;
      $display("FAIL free_and_alloc_d: v%b host_d %h, expected v1 %h", host_d_valid, host_d, expd);
    end
    checks++;
    if (device_e !== 1'b1) begin
      errors++;
      $display("FAIL free_and_alloc_e: device_e=%0d, expected 1", device_e);
    end
    @(posedge clk_i); #1;
    device_d_valid = 1'b0;
    host_e_valid   = 1'b0;
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b1, rnd64()), 2'd0, "fa_realloc_0");
    e_beat(2'd0, 1'b1, "fa_e0");
    e_beat(2'd1, 1'b0, "fa_e1");
  endtask

  task automatic test_reset_mid_burst();
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b0, rnd64()), 2'd0, "mid_pre_0");
    for (int b = 0; b < 3; b++) begin
      d_beat(mk_dd(OP_GRANT_DATA, 3'd6, 1'b1, rnd64()), 2'd1, "mid_burst_beat");
    end
    host_d_ready   = 1'b0;
    rst_i          = 1'b1;
    device_d       = mk_dd(OP_GRANT_DATA, 3'd6, 1'b1, rnd64());
    device_d_valid = 1'b1;
    #4;
    checks++;
    if (host_d_valid !== 1'b1 || host_d.sink !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_state: host_d_valid=%b sink=%0d, expected 1/0", host_d_valid, host_d.sink);
    end
    @(posedge clk_i); #1;
    device_d_valid = 1'b0;
    @(posedge clk_i); #1;
    rst_i        = 1'b0;
    host_d_ready = 1'b1;
    @(posedge clk_i); #1;
    for (int b = 0; b < 8; b++) begin
      d_beat(mk_dd(OP_GRANT_DATA, 3'd6, 1'b1, rnd64()), 2'd0, "post_reset_burst_beat");
    end
    d_beat(mk_dd(OP_GRANT, 3'd6, 1'b0, rnd64()), 2'd1, "post_reset_grant");
    e_beat(2'd0, 1'b1, "post_reset_e0");
    e_beat(2'd1, 1'b0, "post_reset_e1");
  endtask

  initial begin
    rst_i          = 1'b1;
    host_a_valid   = 1'b0;
    host_a         = '0;
    host_b_ready   = 1'b1;
    host_c_valid   = 1'b0;
    host_c         = '0;
    host_d_ready   = 1'b0;
    host_e_valid   = 1'b0;
    host_e         = '0;
    device_a_ready = 1'b1;
    device_b_valid = 1'b0;
    device_b       = '0;
    device_c_ready = 1'b1;
    device_d_valid = 1'b0;
    device_d       = '0;
    device_e_ready = 1'b0;

    test_reset();
    test_grant_basic();
    test_grantdata_burst();
    test_full_stall();
    test_ackdata_passthrough();
    test_free_and_alloc();
    test_reset_mid_burst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
